// File: rtl/third_stage_if.sv
// Operand, control and result bundle between the ID/EX register and the EX stage.
// The master side drives the ID/EX values; the slave side (the EX stage) returns EX/MEM results.
interface third_stage_if #(
    parameter int Width = 32
);
    logic [Width-1:0] readData1;
    logic [Width-1:0] readData2;
    logic [Width-1:0] PC;
    logic [63:0]      immediate;
    logic [4:0]       rd;
    logic [3:0]       ALUcontrol;
    logic [7:0]       control;
    logic [4:0]       R1;
    logic [4:0]       R2;

    logic             zero;
    logic [Width-1:0] ALUResult;
    logic [Width-1:0] adderResult;
    logic [Width-1:0] ReadData2;
    logic [4:0]       rd0;
    logic [5:0]       controlSignal;

    modport master (
        output readData1, readData2, PC, immediate, rd, ALUcontrol, control, R1, R2,
        input  zero, ALUResult, adderResult, ReadData2, rd0, controlSignal
    );

    modport slave (
        input  readData1, readData2, PC, immediate, rd, ALUcontrol, control, R1, R2,
        output zero, ALUResult, adderResult, ReadData2, rd0, controlSignal
    );
endinterface

// File: rtl/third_stage.sv
// RISC-V execute stage: operand select with x0 suppression, ALU, branch target adder,
// and the EX/MEM pipeline register (loads every edge, synchronous active-high reset).
module third_stage #(
    parameter int Width = 32
) (
    input  logic          clk,
    input  logic          rst,
    third_stage_if.slave  bus
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    logic [Width-1:0] imm_w;
    logic [Width-1:0] rs2_val;
    logic [Width-1:0] op_a;
    logic [Width-1:0] op_b;
    logic [4:0]       shamt;

    logic             zero_d,          zero_q;
    logic [Width-1:0] alu_result_d,    alu_result_q;
    logic [Width-1:0] adder_result_d,  adder_result_q;
    logic [Width-1:0] read_data2_d,    read_data2_q;
    logic [4:0]       rd_d,            rd_q;
    logic [5:0]       control_signal_d, control_signal_q;

    // Only the low Width bits of the 64-bit immediate feed the datapath.
    logic unused_imm_hi;
    assign unused_imm_hi = ^bus.immediate[63:Width];

    always_comb begin
        imm_w   = bus.immediate[Width-1:0];
        rs2_val = (bus.R2 == 5'd0) ? '0 : bus.readData2;
        if (bus.control[1]) begin
            op_a = bus.PC;
        end else begin
            op_a = (bus.R1 == 5'd0) ? '0 : bus.readData1;
        end
        op_b  = bus.control[0] ? imm_w : rs2_val;
        shamt = op_b[4:0];

        alu_result_d = '0;
        case (bus.ALUcontrol)
            ALU_AND:  alu_result_d = op_a & op_b;
            ALU_OR:   alu_result_d = op_a | op_b;
            ALU_ADD:  alu_result_d = op_a + op_b;
            ALU_SUB:  alu_result_d = op_a - op_b;
            ALU_XOR:  alu_result_d = op_a ^ op_b;
            ALU_SLL:  alu_result_d = op_a << shamt;
            ALU_SRL:  alu_result_d = op_a >> shamt;
            ALU_SRA:  alu_result_d = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  alu_result_d = {{(Width-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result_d = {{(Width-1){1'b0}}, (op_a < op_b)};
            ALU_NOR:  alu_result_d = ~(op_a | op_b);
            default:  alu_result_d = '0;
        endcase

        zero_d           = (alu_result_d == '0);
        adder_result_d   = bus.PC + (imm_w << 1);
        read_data2_d     = rs2_val;
        rd_d             = bus.rd;
        control_signal_d = bus.control[7:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q           <= 1'b0;
            alu_result_q     <= '0;
            adder_result_q   <= '0;
            read_data2_q     <= '0;
            rd_q             <= '0;
            control_signal_q <= '0;
        end else begin
            zero_q           <= zero_d;
            alu_result_q     <= alu_result_d;
            adder_result_q   <= adder_result_d;
            read_data2_q     <= read_data2_d;
            rd_q             <= rd_d;
            control_signal_q <= control_signal_d;
        end
    end

    assign bus.zero          = zero_q;
    assign bus.ALUResult     = alu_result_q;
    assign bus.adderResult   = adder_result_q;
    assign bus.ReadData2     = read_data2_q;
    assign bus.rd0           = rd_q;
    assign bus.controlSignal = control_signal_q;

endmodule

// File: tb/tb_third_stage.sv
// Scoreboard bench for third_stage: driver pushes model predictions, monitor pops and
// compares one cycle later. Directed vectors first, then a randomized stream with reset pulses.
module tb_third_stage;

    typedef struct {
        logic        zero;
        logic [31:0] alu;
        logic [31:0] adder;
        logic [31:0] rd2;
        logic [4:0]  rd0;
        logic [5:0]  cs;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    third_stage_if #(.Width(32)) bus ();

    third_stage #(.Width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] pow2(input int sh);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < sh; i++) p = p * 2;
        return 32'(p);
    endfunction

    function automatic exp_t model(input logic r, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic [31:0] pc, input logic [63:0] imm, input logic [4:0] rdi,
                                   input logic [3:0] op, input logic [7:0] ctrl,
                                   input logic [4:0] r1, input logic [4:0] r2, input string tag);
        exp_t e;
        logic [31:0] a, b, rs2v, res;
        longint unsigned wide;
        int sh;
        e.tag = tag;
        if (r) begin
            e.zero = 1'b0; e.alu = 0; e.adder = 0; e.rd2 = 0; e.rd0 = 0; e.cs = 0;
            return e;
        end
        rs2v = (r2 == 0) ? 32'd0 : d2;
        if (ctrl[1]) a = pc;
        else         a = (r1 == 0) ? 32'd0 : d1;
        b  = ctrl[0] ? imm[31:0] : rs2v;
        sh = int'(b % 32);
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  begin wide = longint'(a) + longint'(b); res = 32'(wide); end
            4'd6:  begin wide = 64'h1_0000_0000 + longint'(a) - longint'(b); res = 32'(wide); end
            4'd3:  res = a ^ b;
            4'd4:  begin wide = longint'(a) * longint'(pow2(sh)); res = 32'(wide); end
            4'd5:  res = a / pow2(sh);
            4'd8:  res = a[31] ? ~((~a) / pow2(sh)) : a / pow2(sh);
            4'd7:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  res = (a < b) ? 32'd1 : 32'd0;
            4'd12: res = ~(a | b);
            default: res = 32'd0;
        endcase
        e.alu   = res;
        e.zero  = (res == 32'd0);
        wide    = longint'(pc) + 2 * longint'(imm[31:0]);
        e.adder = 32'(wide);
        e.rd2   = rs2v;
        e.rd0   = rdi;
        e.cs    = ctrl[7:2];
        return e;
    endfunction

    task automatic drive(input logic r, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pc, input logic [63:0] imm, input logic [4:0] rdi,
                         input logic [3:0] op, input logic [7:0] ctrl,
                         input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        rst            = r;
        bus.readData1  = d1;
        bus.readData2  = d2;
        bus.PC         = pc;
        bus.immediate  = imm;
        bus.rd         = rdi;
        bus.ALUcontrol = op;
        bus.control    = ctrl;
        bus.R1         = r1;
        bus.R2         = r2;
        exp_q.push_back(model(r, d1, d2, pc, imm, rdi, op, ctrl, r1, r2, tag));
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s got=0x%08h expected=0x%08h", tag, name, got, want);
        end
    endtask

    // Monitor: one output word per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("zero",          e.tag, {31'd0, bus.zero},        {31'd0, e.zero});
                chk("ALUResult",     e.tag, bus.ALUResult,            e.alu);
                chk("adderResult",   e.tag, bus.adderResult,          e.adder);
                chk("ReadData2",     e.tag, bus.ReadData2,            e.rd2);
                chk("rd0",           e.tag, {27'd0, bus.rd0},         {27'd0, e.rd0});
                chk("controlSignal", e.tag, {26'd0, bus.controlSignal}, {26'd0, e.cs});
            end
        end
    end

    initial begin
        logic        r;
        logic [31:0] d1, d2, pc;
        logic [63:0] imm;
        logic [4:0]  r1, r2, rdi;
        logic [3:0]  op;
        logic [7:0]  ctrl;

        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h400, 64'h77, 5'd9, 4'd2, 8'hFF, 5'd3, 5'd4, "reset");
        drive(1'b0, 32'd0, 32'd0, 32'd0, 64'd1, 5'd1, 4'b0001, 8'h01, 5'd1, 5'd1, "first");
        drive(1'b0, 32'd7, 32'd7, 32'd0, 64'd0, 5'd5, 4'b0110, 8'h00, 5'd1, 5'd2, "sub_zero");
        drive(1'b0, 32'd7, 32'd7, 32'd0, 64'd0, 5'd5, 4'b0010, 8'h00, 5'd1, 5'd2, "add");
        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 64'd0, 5'd6, 4'b0111, 8'h00, 5'd1, 5'd2, "slt");
        drive(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 64'd0, 5'd6, 4'b1001, 8'h00, 5'd1, 5'd2, "sltu");
        drive(1'b0, 32'h8000_0000, 32'd4, 32'd0, 64'd0, 5'd7, 4'b1000, 8'h00, 5'd1, 5'd2, "sra");
        drive(1'b0, 32'h55, 32'h66, 32'd0, 64'd0, 5'd8, 4'b0010, 8'h00, 5'd0, 5'd0, "x0");
        drive(1'b0, 32'd0, 32'd0, 32'h100, 64'hFFFF_FFFF_FFFF_FFFC, 5'd10, 4'b0010, 8'h03, 5'd1, 5'd1, "pc_path");
        drive(1'b0, 32'd0, 32'd0, 32'h100, 64'd0, 5'd11, 4'b0010, 8'hFC, 5'd1, 5'd1, "ctrl_fwd");
        drive(1'b0, 32'd0, 32'd0, 32'hFFFF_FFFE, 64'd2, 5'd12, 4'b0010, 8'h00, 5'd1, 5'd1, "wrap");
        drive(1'b0, 32'd3, 32'd5, 32'd8, 64'd0, 5'd13, 4'b1111, 8'h00, 5'd1, 5'd2, "undef_op");
        drive(1'b1, 32'd3, 32'd5, 32'd8, 64'd4, 5'd13, 4'b0010, 8'hFF, 5'd1, 5'd2, "mid_reset");
        drive(1'b0, 32'd3, 32'd5, 32'd8, 64'd4, 5'd13, 4'b0010, 8'hFF, 5'd1, 5'd2, "post_reset");

        for (int i = 0; i < 300; i++) begin
            r    = ($urandom_range(0, 29) == 0);
            d1   = $urandom;
            d2   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h1F) : $urandom;
            pc   = $urandom;
            imm  = {$urandom, $urandom};
            rdi  = 5'($urandom);
            op   = 4'($urandom);
            ctrl = 8'($urandom);
            r1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            drive(r, d1, d2, pc, imm, rdi, op, ctrl, r1, r2, r ? "rand_rst" : "rand");
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/third_stage.md
Name: third_stage

Overview:
- Execute (EX) stage of a 5-stage 32-bit RISC-V pipeline, including the EX/MEM pipeline register.
- Selects ALU operands, performs the ALU operation and computes the branch target (PC + imm<<1).
- Registers results, the store data, the destination register and the downstream control bits for the MEM stage.
- Operand forwarding and hazard detection are outside this block.

Parameters:
- Width, 32, datapath width of operands, PC and results.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- readData1  input  Width  register-file operand rs1
- readData2  input  Width  register-file operand rs2
- PC  input  Width  PC of the instruction in EX
- immediate  input  64  sign-extended immediate; only bits [Width-1:0] are used
- rd  input  5  destination register index
- ALUcontrol  input  4  ALU operation select
- control  input  8  control bundle from ID/EX (bit map below)
- R1  input  5  rs1 index
- R2  input  5  rs2 index
- zero  output  1  registered flag: ALU result == 0
- ALUResult  output  Width  registered ALU result
- adderResult  output  Width  registered branch target
- ReadData2  output  Width  registered store data
- rd0  output  5  registered destination index
- controlSignal  output  6  registered MEM/WB control bits

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). Reset overrides all other activity.
- Every output is registered; latency is 1 cycle from inputs to outputs. No handshake, no stall: the register loads every rising edge.
- While rst=1 at a rising edge, all outputs load 0 (zero=0, ALUResult=0, adderResult=0, ReadData2=0, rd0=0, controlSignal=0).
- Reset asserted mid-operation discards the in-flight instruction. The first non-reset edge loads the current inputs.
- Control bit map:
  - control[0] = ALUSrc (1: operand B = immediate[Width-1:0]; 0: readData2)
  - control[1] = ASel (1: operand A = PC; 0: readData1)
  - control[7:2] forwarded unchanged to controlSignal[5:0]
- x0 handling:
  - If ASel=0 and R1==0, operand A = 0 regardless of readData1.
  - If R2==0, the rs2 value is 0. This zeroes operand B when ALUSrc=0, and zeroes ReadData2.
- ReadData2 output = rs2 value after x0 handling. It is independent of ALUSrc.
- ALU operations, all modulo 2^Width. Shift amount is B[4:0].
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A-B)
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 1000 SRA (arithmetic)
  - 0111 SLT (signed; result 1 or 0)
  - 1001 SLTU (unsigned)
  - 1100 NOR
  - Any other code: result 0
- zero = 1 exactly when the ALU result (pre-register) is all zeros; it is registered with ALUResult. Undefined codes therefore give zero=1.
- adderResult = PC + (immediate[Width-1:0] << 1), truncated to Width bits and wrapping on overflow. It always uses PC, never the operand-A mux.
- Overflow and carry are not reported. ADD/SUB wrap silently.
- rd0 = rd, registered. R1 and R2 are consumed only by the x0 logic and are not output.

Test Plan:
- rst=1 for one edge with arbitrary inputs -> all outputs 0. Then rst=0 with readData1=0, readData2=0, PC=0, immediate=1, rd=1, ALUcontrol=0001, control=8'h01, R1=1, R2=1 -> after next edge: ALUResult=1, zero=0, adderResult=2, ReadData2=0, rd0=1, controlSignal=0.
- readData1=7, readData2=7, R1=1, R2=2, control=8'h00, ALUcontrol=0110 -> ALUResult=0, zero=1. Same operands with ALUcontrol=0010 -> ALUResult=14, zero=0.
- Signed compare: readData1=0xFFFFFFFF, readData2=1, control=8'h00. SLT gives ALUResult=1; SLTU gives ALUResult=0. SRA by 4 of 0x80000000 -> 0xF8000000.
- x0: R1=0 with readData1=0x55, R2=0 with readData2=0x66, ADD, control=8'h00 -> ALUResult=0, ReadData2=0, zero=1.
- PC path: PC=0x100, immediate=0xFFFFFFFFFFFFFFFC (-4), control=8'h03, ADD -> ALUResult=0xFC, adderResult=0xF8. control=8'hFC -> controlSignal=6'h3F.
- Wrap: PC=0xFFFFFFFE, immediate=2 -> adderResult=0x00000002. Assert rst during a stream -> the next edge outputs all zero; deassert -> the next edge outputs the current inputs' result.
